// File: rtl/idli_sqi_resp.sv
// idli_sqi_resp -- SQI (quad serial) memory responder.
//
// Behaves as a byte-addressed memory of 2^DEPTH_LOG2 bytes behind a
// 4-bit serial interface clocked by i_clk. Every field travels MSB nibble
// first. A transaction consists of an instruction byte, a 24-bit address and
// then either read data (READ 0x03, after two dummy nibbles) or write data
// (WRITE 0x02). The address auto-increments per byte and wraps at the top of
// the array.
//
// Ports
//   i_clk         in   clock; also the SQI serial clock
//   i_rst_n       in   asynchronous active-low reset
//   i_sqi_cs_n    in   chip select from the initiator, active-low
//   i_sqi_sio     in   [3:0] nibble driven by the initiator
//   o_sqi_sio     out  [3:0] read-data nibble to the initiator
//   o_sqi_sio_oe  out  o_sqi_sio is valid and driven
//
// state   | meaning
// IDLE    | waiting for a CS high-to-low transition
// CMD     | high instruction nibble held, decoding at the low nibble
// ADDR    | shifting in the six address nibbles
// DUMMY   | two dummy nibbles of a READ; the last one preloads read data
// RD      | driving read nibbles, one per edge
// WR      | collecting write nibbles, storing a byte per low nibble
// IGNORE  | unknown instruction; do nothing until CS rises

module idli_sqi_resp #(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sqi_cs_n,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_oe
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_RD     = 3'd4,
    ST_WR     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  state_t                state_q,   state_d;
  logic [2:0]            cnt_q,     cnt_d;
  logic [3:0]            nib_q,     nib_d;
  logic                  is_read_q, is_read_d;
  logic [DEPTH_LOG2-1:0] addr_q,    addr_d;
  logic                  cs_prev_q, cs_prev_d;
  logic [3:0]            sio_q,     sio_d;
  logic                  oe_q,      oe_d;

  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            rd_byte;

  logic [7:0] mem [2**DEPTH_LOG2];

  assign rd_byte = mem[addr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nib_d     = nib_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    cs_prev_d = i_sqi_cs_n;
    sio_d     = 4'h0;
    oe_d      = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {nib_q, i_sqi_sio};

    if (i_sqi_cs_n) begin
      // CS high wins over every other transition, including a half-collected
      // write byte, which is simply dropped.
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Only a high-to-low transition starts a transaction; cs_prev_q
          // resets low so CS held low through reset is not a start.
          if (cs_prev_q) begin
            nib_d   = i_sqi_sio;
            state_d = ST_CMD;
            cnt_d   = 3'd0;
          end
        end
        ST_CMD: begin
          cnt_d = 3'd0;
          if ({nib_q, i_sqi_sio} == 8'h03) begin
            is_read_d = 1'b1;
            state_d   = ST_ADDR;
          end else if ({nib_q, i_sqi_sio} == 8'h02) begin
            is_read_d = 1'b0;
            state_d   = ST_ADDR;
          end else begin
            state_d   = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          // Six nibbles shift through; bits above DEPTH_LOG2 fall off the top.
          addr_d = {addr_q[DEPTH_LOG2-5:0], i_sqi_sio};
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            state_d = is_read_q ? ST_DUMMY : ST_WR;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_DUMMY: begin
          if (cnt_q == 3'd1) begin
            // Preload the first read nibble so it is stable for the next edge.
            state_d = ST_RD;
            sio_d   = rd_byte[7:4];
            oe_d    = 1'b1;
            cnt_d   = 3'd1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_RD: begin
          oe_d = 1'b1;
          if (cnt_q[0]) begin
            sio_d  = rd_byte[3:0];
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = 3'd0;
          end else begin
            sio_d  = rd_byte[7:4];
            cnt_d  = 3'd1;
          end
        end
        ST_WR: begin
          if (!cnt_q[0]) begin
            nib_d = i_sqi_sio;
            cnt_d = 3'd1;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = 3'd0;
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      nib_q     <= 4'h0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      cs_prev_q <= 1'b0;
      sio_q     <= 4'h0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nib_q     <= nib_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      cs_prev_q <= cs_prev_d;
      sio_q     <= sio_d;
      oe_q      <= oe_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign o_sqi_sio    = sio_q;
  assign o_sqi_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_resp.sv
// Directed testbench for idli_sqi_resp. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.

module tb_idli_sqi_resp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       oe;

  always #5 clk = ~clk;

  idli_sqi_resp #(.DEPTH_LOG2(17)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sqi_cs_n   (cs_n),
    .i_sqi_sio    (sio_in),
    .o_sqi_sio    (sio_out),
    .o_sqi_sio_oe (oe)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [3:0] rd_nib [0:31];
  logic       rd_oe  [0:31];
  logic       rd_dummy_oe;
  logic       rd_end_oe;
  logic [3:0] rd_end_sio;
  logic       wr_oe_any;

  // One SQI edge: drive at the falling edge, observe just after the rising edge.
  task automatic send(input logic cs, input logic [3:0] nib);
    @(negedge clk);
    cs_n   = cs;
    sio_in = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    send(1'b0, cmd[7:4]);
    send(1'b0, cmd[3:0]);
    for (int i = 5; i >= 0; i--) send(1'b0, addr[4*i +: 4]);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [63:0] data, input int nnib);
    wr_oe_any = 1'b0;
    send(1'b1, 4'h0);
    send_hdr(8'h02, addr);
    wr_oe_any = wr_oe_any | oe;
    for (int i = 0; i < nnib; i++) begin
      send(1'b0, data[63-4*i -: 4]);
      wr_oe_any = wr_oe_any | oe;
    end
    send(1'b1, 4'h0);
  endtask

  task automatic do_read(input logic [23:0] addr, input int nbytes, input bit pre_idle);
    if (pre_idle) send(1'b1, 4'h0);
    send_hdr(8'h03, addr);
    send(1'b0, 4'h0);
    rd_dummy_oe = oe;
    for (int k = 0; k < 2*nbytes; k++) begin
      send(1'b0, 4'h0);
      rd_nib[k] = sio_out;
      rd_oe[k]  = oe;
    end
    send(1'b1, 4'h0);
    rd_end_oe  = oe;
    rd_end_sio = sio_out;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    cs_n   = 1'b1;
    sio_in = 4'h0;
    #2;
    vec_cnt++;
    if (oe !== 1'b0 || sio_out !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_async: got oe=%b sio=%h, want oe=0 sio=0", oe, sio_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 4'h0);
    vec_cnt++;
    if (oe !== 1'b0 || sio_out !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_idle: got oe=%b sio=%h, want oe=0 sio=0", oe, sio_out);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] exp;
    exp = 16'hA53C;
    do_write(24'h000100, 64'hA53C_0000_0000_0000, 4);
    vec_cnt++;
    if (wr_oe_any !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_oe: got oe=%b during write, want 0", wr_oe_any);
    end
    do_read(24'h000100, 2, 1'b1);
    vec_cnt++;
    if (rd_dummy_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_dummy_oe: got %b, want 0", rd_dummy_oe);
    end
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (rd_oe[k] !== 1'b1 || rd_nib[k] !== exp[15-4*k -: 4]) begin
        err_cnt++;
        $display("FAIL wr_rd nib%0d: got oe=%b sio=%h, want oe=1 sio=%h", k, rd_oe[k], rd_nib[k], exp[15-4*k -: 4]);
      end
    end
    vec_cnt++;
    if (rd_end_oe !== 1'b0 || rd_end_sio !== 4'h0) begin
      err_cnt++;
      $display("FAIL rd_end: got oe=%b sio=%h, want oe=0 sio=0", rd_end_oe, rd_end_sio);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    exp = 16'h1122;
    do_write(24'h01FFFF, 64'h1122_0000_0000_0000, 4);
    do_read(24'h01FFFF, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (rd_oe[k] !== 1'b1 || rd_nib[k] !== exp[15-4*k -: 4]) begin
        err_cnt++;
        $display("FAIL wrap_rd nib%0d: got oe=%b sio=%h, want oe=1 sio=%h", k, rd_oe[k], rd_nib[k], exp[15-4*k -: 4]);
      end
    end
    do_read(24'h000000, 1, 1'b1);
    vec_cnt++;
    if ({rd_nib[0], rd_nib[1]} !== 8'h22) begin
      err_cnt++;
      $display("FAIL wrap_zero: got %h, want 22", {rd_nib[0], rd_nib[1]});
    end
  endtask

  task automatic test_partial();
    do_write(24'h000010, 64'h005A_0000_0000_0000, 4);
    do_write(24'h000010, 64'h7E90_0000_0000_0000, 3);
    do_read(24'h000010, 2, 1'b1);
    vec_cnt++;
    if ({rd_nib[0], rd_nib[1]} !== 8'h7E) begin
      err_cnt++;
      $display("FAIL partial_full: got %h, want 7e", {rd_nib[0], rd_nib[1]});
    end
    vec_cnt++;
    if ({rd_nib[2], rd_nib[3]} !== 8'h5A) begin
      err_cnt++;
      $display("FAIL partial_drop: got %h, want 5a", {rd_nib[2], rd_nib[3]});
    end
  endtask

  task automatic test_bad_cmd();
    logic any_oe;
    do_write(24'h000020, 64'h3C00_0000_0000_0000, 2);
    any_oe = 1'b0;
    send(1'b1, 4'h0);
    send(1'b0, 4'hF);
    send(1'b0, 4'hF);
    any_oe = any_oe | oe;
    // Looks like an address of 0x000020 followed by 0x55 data if misdecoded.
    for (int i = 0; i < 20; i++) begin
      send(1'b0, (i == 4) ? 4'h2 : ((i < 6) ? 4'h0 : 4'h5));
      any_oe = any_oe | oe;
    end
    send(1'b1, 4'h0);
    vec_cnt++;
    if (any_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL bad_cmd_oe: got oe=%b, want 0", any_oe);
    end
    do_read(24'h000020, 1, 1'b1);
    vec_cnt++;
    if (rd_oe[0] !== 1'b1 || {rd_nib[0], rd_nib[1]} !== 8'h3C) begin
      err_cnt++;
      $display("FAIL bad_cmd_mem: got oe=%b data=%h, want oe=1 data=3c", rd_oe[0], {rd_nib[0], rd_nib[1]});
    end
  endtask

  task automatic test_reset_mid_read();
    logic any_oe;
    do_write(24'h000040, 64'hA1B2_0000_0000_0000, 4);
    send(1'b1, 4'h0);
    send_hdr(8'h03, 24'h000040);
    for (int e = 8; e <= 11; e++) send(1'b0, 4'h0);
    vec_cnt++;
    if (oe !== 1'b1 || sio_out !== 4'hB) begin
      err_cnt++;
      $display("FAIL rst_rd_pre: got oe=%b sio=%h, want oe=1 sio=b", oe, sio_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (oe !== 1'b0 || sio_out !== 4'h0) begin
      err_cnt++;
      $display("FAIL rst_rd_async: got oe=%b sio=%h, want oe=0 sio=0", oe, sio_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_oe = 1'b0;
    send_hdr(8'h03, 24'h000040);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 4'h0);
      any_oe = any_oe | oe;
    end
    vec_cnt++;
    if (any_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_rd_nostart: got oe=%b with CS held low, want 0", any_oe);
    end
    do_read(24'h000040, 2, 1'b1);
    vec_cnt++;
    if ({rd_nib[0], rd_nib[1], rd_nib[2], rd_nib[3]} !== 16'hA1B2) begin
      err_cnt++;
      $display("FAIL rst_rd_after: got %h, want a1b2", {rd_nib[0], rd_nib[1], rd_nib[2], rd_nib[3]});
    end
  endtask

  task automatic test_cs_abort();
    send(1'b1, 4'h0);
    send(1'b0, 4'h0);
    send(1'b0, 4'h3);
    send(1'b0, 4'h0);
    send(1'b0, 4'h0);
    send(1'b0, 4'h0);
    send(1'b1, 4'h1);
    vec_cnt++;
    if (oe !== 1'b0 || sio_out !== 4'h0) begin
      err_cnt++;
      $display("FAIL cs_abort_oe: got oe=%b sio=%h, want oe=0 sio=0", oe, sio_out);
    end
    do_read(24'h000100, 1, 1'b0);
    vec_cnt++;
    if (rd_oe[0] !== 1'b1 || {rd_nib[0], rd_nib[1]} !== 8'hA5) begin
      err_cnt++;
      $display("FAIL cs_abort_next: got oe=%b data=%h, want oe=1 data=a5", rd_oe[0], {rd_nib[0], rd_nib[1]});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    exp = 24'h123456;
    do_write(24'h000200, 64'h1234_5600_0000_0000, 6);
    do_read(24'h000200, 3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      vec_cnt++;
      if (rd_oe[k] !== 1'b1 || rd_nib[k] !== exp[23-4*k -: 4]) begin
        err_cnt++;
        $display("FAIL b2b_rd nib%0d: got oe=%b sio=%h, want oe=1 sio=%h", k, rd_oe[k], rd_nib[k], exp[23-4*k -: 4]);
      end
    end
    do_read(24'h000201, 1, 1'b0);
    vec_cnt++;
    if ({rd_nib[0], rd_nib[1]} !== 8'h34) begin
      err_cnt++;
      $display("FAIL b2b_second: got %h, want 34", {rd_nib[0], rd_nib[1]});
    end
  endtask

  task automatic test_addr_upper();
    // 0x0E0050 has bits above bit 16 set; only the low 17 bits (0x00050) count.
    do_write(24'h0E0050, 64'hC700_0000_0000_0000, 2);
    do_read(24'h000050, 1, 1'b1);
    vec_cnt++;
    if ({rd_nib[0], rd_nib[1]} !== 8'hC7) begin
      err_cnt++;
      $display("FAIL addr_upper: got %h, want c7", {rd_nib[0], rd_nib[1]});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_partial();
    test_bad_cmd();
    test_reset_mid_read();
    test_cs_abort();
    test_back_to_back();
    test_addr_upper();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
